// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states and memory geometry defaults.
package mem_port_arbiter_pkg;

  localparam int MEM_BANDWIDTH = 32;
  localparam int MEM_DATA_W    = MEM_BANDWIDTH * 8;
  localparam int MEM_ADDR_SIZE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot select of the first requester after last_grant.
module mem_port_arbiter_rr_picker #(
  parameter int NUM_CLIENTS = 4,
  parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       last_grant,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic                   valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    // Offsets 1..N put last_grant itself at the lowest priority.
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      idx = IDX_W'((int'(last_grant) + off) % NUM_CLIENTS);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-client round-robin arbiter for a single memory port with per-client auto-incrementing pointers.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_SIZE,
  parameter int MAX_BURST   = 16,
  parameter int LEN_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] client_base_addr,
  input  logic [NUM_CLIENTS-1:0]        client_req,
  input  logic [NUM_CLIENTS-1:0]        client_we,
  input  logic [NUM_CLIENTS*LEN_W-1:0]  client_len,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata,
  output logic [NUM_CLIENTS-1:0]        client_grant,
  output logic [NUM_CLIENTS-1:0]        client_beat_ack,
  output logic [DATA_W-1:0]             client_rdata,
  output logic [NUM_CLIENTS-1:0]        client_rdata_valid,
  output logic [NUM_CLIENTS-1:0]        client_done,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_read_valid,
  output logic                          mem_write_valid,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          busy,
  output logic                          protocol_err
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             we_q, we_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] returned_q, returned_d;
  logic             err_q, err_d;
  logic [ADDR_W-1:0] ptr_q [NUM_CLIENTS];
  logic [ADDR_W-1:0] ptr_d [NUM_CLIENTS];

  logic [ADDR_W-1:0] base_arr  [NUM_CLIENTS];
  logic [LEN_W-1:0]  len_arr   [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_arr [NUM_CLIENTS];

  logic [NUM_CLIENTS-1:0] pick_onehot;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic [LEN_W-1:0]       pick_len;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
      assign base_arr[gi]  = client_base_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]   = client_len[gi*LEN_W +: LEN_W];
      assign wdata_arr[gi] = client_wdata[gi*DATA_W +: DATA_W];

      always_ff @(posedge clk) begin
        if (rst) begin
          ptr_q[gi] <= '0;
        end else begin
          ptr_q[gi] <= ptr_d[gi];
        end
      end
    end
  endgenerate

  mem_port_arbiter_rr_picker #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req        (client_req),
    .last_grant (last_grant_q),
    .grant      (pick_onehot),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
    pick_len = (len_arr[pick_idx] > MAX_LEN) ? MAX_LEN : len_arr[pick_idx];
  end

  assign client_rdata = mem_rdata;
  assign busy         = (state_q != IDLE);
  assign protocol_err = err_q;

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    last_grant_d       = last_grant_q;
    we_d               = we_q;
    len_d              = len_q;
    issued_d           = issued_q;
    returned_d         = returned_q;
    err_d              = err_q;
    ptr_d              = ptr_q;
    client_grant       = '0;
    client_beat_ack    = '0;
    client_rdata_valid = '0;
    client_done        = '0;
    mem_read_valid     = 1'b0;
    mem_write_valid    = 1'b0;
    mem_addr           = ptr_q[owner_q] + ADDR_W'(issued_q);
    mem_wdata          = wdata_arr[owner_q];

    if (state_q != IDLE) client_grant[owner_q] = 1'b1;

    // Read data is only legal while a read burst still expects beats.
    if (mem_rvalid) begin
      if ((state_q == ISSUE || state_q == DRAIN) && !we_q && (returned_q < len_q)) begin
        client_rdata_valid[owner_q] = 1'b1;
        returned_d                  = returned_q + LEN_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    if (start && state_q != IDLE) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < NUM_CLIENTS; i++) ptr_d[i] = base_arr[i];
        end
        if (pick_valid) begin
          owner_d    = pick_idx;
          we_d       = client_we[pick_idx];
          len_d      = pick_len;
          issued_d   = '0;
          returned_d = '0;
          state_d    = (pick_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        mem_read_valid  = !we_q;
        mem_write_valid = we_q;
        if (mem_ready) begin
          issued_d = issued_q + LEN_W'(1);
          if (we_q) client_beat_ack[owner_q] = 1'b1;
          if (issued_d == len_q) begin
            if (we_q || returned_d == len_q) state_d = DONE;
            else                             state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (returned_d == len_q) state_d = DONE;
      end
      DONE: begin
        client_done[owner_q] = 1'b1;
        ptr_d[owner_q]       = ptr_q[owner_q] + ADDR_W'(len_q);
        last_grant_d         = owner_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_CLIENTS - 1);
      we_q         <= 1'b0;
      len_q        <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      len_q        <= len_d;
      issued_q     <= issued_d;
      returned_q   <= returned_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 2-cycle-latency read memory model.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int AW = 16;
  localparam int MB = 16;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst, start;
  logic [N*AW-1:0] client_base_addr;
  logic [N-1:0]    client_req, client_we;
  logic [N*LW-1:0] client_len;
  logic [N*DW-1:0] client_wdata;
  logic [N-1:0]    client_grant, client_beat_ack, client_rdata_valid, client_done;
  logic [DW-1:0]   client_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic mem_read_valid, mem_write_valid, mem_ready, mem_rvalid, busy, protocol_err;

  logic          force_rv;
  logic [1:0]    rv_pipe;
  logic [AW-1:0] ra0, ra1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .NUM_CLIENTS(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB), .LEN_W(LW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .client_base_addr(client_base_addr),
    .client_req(client_req), .client_we(client_we), .client_len(client_len),
    .client_wdata(client_wdata), .client_grant(client_grant),
    .client_beat_ack(client_beat_ack), .client_rdata(client_rdata),
    .client_rdata_valid(client_rdata_valid), .client_done(client_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_valid(mem_read_valid),
    .mem_write_valid(mem_write_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .busy(busy), .protocol_err(protocol_err)
  );

  // Memory model: read data returns two cycles after issue, value = addr ^ 0x5A5A.
  always @(posedge clk) begin
    if (rst) begin
      rv_pipe <= '0;
      ra0     <= '0;
      ra1     <= '0;
    end else begin
      rv_pipe <= {rv_pipe[0], mem_read_valid && mem_ready};
      ra0     <= mem_addr;
      ra1     <= ra0;
    end
  end
  assign mem_rvalid = rv_pipe[1] | force_rv;
  assign mem_rdata  = rv_pipe[1] ? DW'(ra1 ^ 16'h5A5A) : '0;

  // Event recorder sampled mid-cycle; tasks compare deltas against their own expectations.
  int cyc = 0;
  int iss_addr[$];
  int iss_cyc[$];
  int iss_dat[$];
  int rd_dat[$];
  int grant_seq[$];
  int ack_cnt[N];
  int rdv_cnt[N];
  int done_cnt[N];
  int ack_bad = 0;
  logic [N-1:0] prev_grant = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if ((mem_read_valid || mem_write_valid) && mem_ready) begin
      iss_addr.push_back(int'(mem_addr));
      iss_cyc.push_back(cyc);
      if (mem_write_valid) iss_dat.push_back(int'(mem_wdata[15:0]));
    end
    for (int i = 0; i < N; i++) begin
      if (client_beat_ack[i]) ack_cnt[i]++;
      if (client_rdata_valid[i]) begin
        rdv_cnt[i]++;
        rd_dat.push_back(int'(client_rdata[15:0]));
      end
      if (client_done[i]) done_cnt[i]++;
      if (client_grant[i] && !prev_grant[i]) grant_seq.push_back(i);
    end
    if (client_beat_ack != '0 &&
        !(mem_write_valid && mem_ready && client_beat_ack == client_grant)) ack_bad++;
    prev_grant = client_grant;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic w, input int l);
    client_req[c]           = 1'b1;
    client_we[c]            = w;
    client_len[c*LW +: LW]  = LW'(l);
  endtask

  task automatic do_start(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                          input logic [AW-1:0] b2, input logic [AW-1:0] b3);
    client_base_addr = {b3, b2, b1, b0};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, protocol_err, mem_read_valid, mem_write_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, protocol_err, mem_read_valid, mem_write_valid});
    end
    n_checks++;
    if ({client_grant, client_done, client_beat_ack, client_rdata_valid} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_client: got %h expected 0000", {client_grant, client_done, client_beat_ack, client_rdata_valid});
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_read_basic();
    int i0, r0, v0, d0;
    int exp_rd[3] = '{32'h585A, 32'h585B, 32'h5858};
    tick();
    do_start(16'h100, 16'h200, 16'h300, 16'h400);
    i0 = iss_addr.size(); r0 = rd_dat.size(); v0 = rdv_cnt[1]; d0 = done_cnt[1];
    set_req(1, 1'b0, 3);
    for (int k = 0; k < 60 && done_cnt[1] == d0; k++) tick();
    client_req[1] = 1'b0;
    n_checks++;
    if (done_cnt[1] - d0 != 1) begin
      n_fail++; $display("FAIL rd_done: got %0d expected 1", done_cnt[1] - d0);
    end
    n_checks++;
    if (iss_addr.size() - i0 != 3 || rd_dat.size() - r0 != 3 || rdv_cnt[1] - v0 != 3) begin
      n_fail++;
      $display("FAIL rd_counts: issued %0d rvalid %0d expected 3 and 3", iss_addr.size() - i0, rdv_cnt[1] - v0);
    end else begin
      for (int j = 0; j < 3; j++) begin
        n_checks++;
        if (iss_addr[i0+j] != 32'h200 + j) begin
          n_fail++; $display("FAIL rd_addr[%0d]: got %h expected %h", j, iss_addr[i0+j], 32'h200 + j);
        end
        n_checks++;
        if (rd_dat[r0+j] != exp_rd[j]) begin
          n_fail++; $display("FAIL rd_data[%0d]: got %h expected %h", j, rd_dat[r0+j], exp_rd[j]);
        end
      end
    end
    $display("read c1 len3: done");
    i0 = iss_addr.size(); d0 = done_cnt[1];
    set_req(1, 1'b0, 1);
    for (int k = 0; k < 60 && done_cnt[1] == d0; k++) tick();
    client_req[1] = 1'b0;
    n_checks++;
    if (iss_addr.size() != i0 + 1 || iss_addr[i0] != 32'h203) begin
      n_fail++; $display("FAIL ptr1_advance: got %h expected 0203", (iss_addr.size() > i0) ? iss_addr[i0] : -1);
    end
    $display("read c1 len1: done");
  endtask

  task automatic test_rr_order();
    int g0, i0, t0, a0, b0;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    int exp_a[5] = '{0, 0, 0, 0, 1};
    pulse_rst();
    a0 = ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3];
    b0 = ack_bad;
    g0 = grant_seq.size(); i0 = iss_addr.size(); t0 = iss_dat.size();
    for (int c = 0; c < N; c++) set_req(c, 1'b1, 1);
    for (int k = 0; k < 80 && grant_seq.size() - g0 < 5; k++) tick();
    client_req = '0;
    repeat (4) tick();
    n_checks++;
    if (grant_seq.size() - g0 != 5 || iss_addr.size() - i0 != 5 || iss_dat.size() - t0 != 5) begin
      n_fail++; $display("FAIL rr_count: grants %0d issues %0d expected 5 and 5", grant_seq.size() - g0, iss_addr.size() - i0);
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_checks++;
        if (grant_seq[g0+j] != exp_g[j] || iss_addr[i0+j] != exp_a[j] || iss_dat[t0+j] != 32'hC000 + exp_g[j]) begin
          n_fail++;
          $display("FAIL rr_grant[%0d]: got c%0d addr %h data %h expected c%0d addr %h data %h",
                   j, grant_seq[g0+j], iss_addr[i0+j], iss_dat[t0+j], exp_g[j], exp_a[j], 32'hC000 + exp_g[j]);
        end
      end
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (iss_cyc[i0+j+1] - iss_cyc[i0+j] != 3) begin
          n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", j, iss_cyc[i0+j+1] - iss_cyc[i0+j]);
        end
      end
    end
    n_checks++;
    if (ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - a0 != 5 || ack_bad != b0) begin
      n_fail++; $display("FAIL rr_acks: got %0d misaligned %0d expected 5 and 0",
                         ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3] - a0, ack_bad - b0);
    end
    $display("round robin: 5 grants checked");
  endtask

  task automatic test_ready_toggle();
    int i0, a0, b0, d0;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int exp_off[4] = '{0, 3, 4, 6};
    do_start(16'h100, 16'h200, 16'h300, 16'h400);
    i0 = iss_addr.size(); a0 = ack_cnt[2]; b0 = ack_bad; d0 = done_cnt[2];
    set_req(2, 1'b1, 4);
    for (int j = 0; j < 7; j++) begin
      tick();
      mem_ready = (pat[j] != 0);
    end
    tick();
    mem_ready = 1'b1;
    for (int k = 0; k < 20 && done_cnt[2] == d0; k++) tick();
    client_req[2] = 1'b0;
    n_checks++;
    if (ack_cnt[2] - a0 != 4 || ack_bad != b0 || done_cnt[2] - d0 != 1) begin
      n_fail++; $display("FAIL rt_acks: acks %0d misaligned %0d done %0d expected 4 0 1",
                         ack_cnt[2] - a0, ack_bad - b0, done_cnt[2] - d0);
    end
    n_checks++;
    if (iss_addr.size() - i0 != 4) begin
      n_fail++; $display("FAIL rt_beats: got %0d expected 4", iss_addr.size() - i0);
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (iss_addr[i0+j] != 32'h300 + j || iss_cyc[i0+j] - iss_cyc[i0] != exp_off[j]) begin
          n_fail++; $display("FAIL rt_beat[%0d]: got addr %h offset %0d expected addr %h offset %0d",
                             j, iss_addr[i0+j], iss_cyc[i0+j] - iss_cyc[i0], 32'h300 + j, exp_off[j]);
        end
      end
    end
    $display("write c2 len4 ready toggling: done");
  endtask

  task automatic test_wrap();
    int i0, v0, d0, r0;
    int exp_a[4] = '{32'hFFFE, 32'hFFFF, 32'h0000, 32'h0001};
    do_start(16'hFFFE, 16'h200, 16'h300, 16'h400);
    i0 = iss_addr.size(); v0 = rdv_cnt[0]; d0 = done_cnt[0]; r0 = rd_dat.size();
    set_req(0, 1'b0, 4);
    for (int k = 0; k < 60 && done_cnt[0] == d0; k++) tick();
    client_req[0] = 1'b0;
    n_checks++;
    if (iss_addr.size() - i0 != 4 || rdv_cnt[0] - v0 != 4) begin
      n_fail++; $display("FAIL wrap_counts: issued %0d rvalid %0d expected 4 and 4", iss_addr.size() - i0, rdv_cnt[0] - v0);
    end else begin
      for (int j = 0; j < 4; j++) begin
        n_checks++;
        if (iss_addr[i0+j] != exp_a[j]) begin
          n_fail++; $display("FAIL wrap_addr[%0d]: got %h expected %h", j, iss_addr[i0+j], exp_a[j]);
        end
      end
      n_checks++;
      if (rd_dat[r0+3] != 32'h5A5B) begin
        n_fail++; $display("FAIL wrap_rdata: got %h expected 5a5b", rd_dat[r0+3]);
      end
    end
    i0 = iss_addr.size(); d0 = done_cnt[0];
    set_req(0, 1'b0, 1);
    for (int k = 0; k < 60 && done_cnt[0] == d0; k++) tick();
    client_req[0] = 1'b0;
    n_checks++;
    if (iss_addr.size() != i0 + 1 || iss_addr[i0] != 32'h0002) begin
      n_fail++; $display("FAIL wrap_ptr: got %h expected 0002", (iss_addr.size() > i0) ? iss_addr[i0] : -1);
    end
    $display("read c0 wrap: done");
  endtask

  task automatic test_edge_cases();
    int i0, g0, d0, a0;
    // Zero-length burst: grant and done without any memory issue.
    i0 = iss_addr.size(); g0 = grant_seq.size(); d0 = done_cnt[3];
    set_req(3, 1'b0, 0);
    for (int k = 0; k < 20 && done_cnt[3] == d0; k++) tick();
    client_req[3] = 1'b0;
    n_checks++;
    if (iss_addr.size() != i0 || grant_seq.size() != g0 + 1 || done_cnt[3] != d0 + 1 ||
        (grant_seq.size() > g0 && grant_seq[g0] != 3)) begin
      n_fail++; $display("FAIL len0: issues %0d grants %0d done %0d expected 0 1 1",
                         iss_addr.size() - i0, grant_seq.size() - g0, done_cnt[3] - d0);
    end
    $display("len0 c3: done");
    // Oversized length clamps to 16 beats.
    i0 = iss_addr.size(); d0 = done_cnt[3]; a0 = ack_cnt[3];
    set_req(3, 1'b1, 20);
    for (int k = 0; k < 60 && done_cnt[3] == d0; k++) tick();
    client_req[3] = 1'b0;
    n_checks++;
    if (iss_addr.size() - i0 != 16 || ack_cnt[3] - a0 != 16) begin
      n_fail++; $display("FAIL clamp_beats: issues %0d acks %0d expected 16", iss_addr.size() - i0, ack_cnt[3] - a0);
    end else begin
      n_checks++;
      if (iss_addr[i0] != 32'h400 || iss_addr[i0+15] != 32'h40F) begin
        n_fail++; $display("FAIL clamp_addr: got %h..%h expected 0400..040f", iss_addr[i0], iss_addr[i0+15]);
      end
    end
    $display("len20 c3: done");
    // Stray read data while idle.
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++; $display("FAIL err_clean: got %b expected 0", protocol_err);
    end
    tick();
    force_rv = 1'b1;
    @(negedge clk);
    n_checks++;
    if (client_rdata_valid !== 4'b0) begin
      n_fail++; $display("FAIL stray_rvalid: got %b expected 0000", client_rdata_valid);
    end
    tick();
    force_rv = 1'b0;
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL stray_err: got %b expected 1", protocol_err);
    end
    $display("stray rvalid: done");
    // start while busy is ignored and flagged.
    tick();
    pulse_rst();
    do_start(16'h100, 16'h200, 16'h300, 16'h400);
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b0) begin
      n_fail++; $display("FAIL err_after_rst: got %b expected 0", protocol_err);
    end
    d0 = done_cnt[1];
    tick();
    set_req(1, 1'b0, 2);
    tick();
    client_base_addr = {N{16'hAAAA}};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && done_cnt[1] == d0; k++) tick();
    client_req[1] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_err: got %b expected 1", protocol_err);
    end
    i0 = iss_addr.size(); d0 = done_cnt[1];
    tick();
    set_req(1, 1'b0, 1);
    for (int k = 0; k < 40 && done_cnt[1] == d0; k++) tick();
    client_req[1] = 1'b0;
    n_checks++;
    if (iss_addr.size() != i0 + 1 || iss_addr[i0] != 32'h202) begin
      n_fail++; $display("FAIL busy_start_ptr: got %h expected 0202", (iss_addr.size() > i0) ? iss_addr[i0] : -1);
    end
    $display("start while busy: done");
  endtask

  task automatic test_reset_mid_burst();
    int d0, g0;
    client_wdata = '0;
    mem_ready    = 1'b1;
    d0 = done_cnt[0];
    tick();
    set_req(0, 1'b0, 4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    client_req = '0;
    @(negedge clk);
    n_checks++;
    if ({busy, protocol_err, mem_read_valid, mem_write_valid, client_grant, client_done,
         client_beat_ack, client_rdata_valid} !== 20'h0 || mem_addr !== '0 ||
        client_rdata !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL midrst_outputs: got ctrl %h addr %h expected all 0",
                         {busy, protocol_err, mem_read_valid, mem_write_valid, client_grant,
                          client_done, client_beat_ack, client_rdata_valid}, mem_addr);
    end
    repeat (5) tick();
    n_checks++;
    if (done_cnt[0] != d0) begin
      n_fail++; $display("FAIL midrst_done: got %0d expected 0", done_cnt[0] - d0);
    end
    $display("reset mid burst: done");
    g0 = grant_seq.size();
    set_req(0, 1'b1, 1);
    set_req(2, 1'b1, 1);
    for (int k = 0; k < 40 && grant_seq.size() - g0 < 2; k++) tick();
    client_req = '0;
    repeat (3) tick();
    n_checks++;
    if (grant_seq.size() - g0 != 2 || grant_seq[g0] != 0 || grant_seq[g0+1] != 2) begin
      n_fail++; $display("FAIL midrst_order: got %0d grants first c%0d expected c0 then c2",
                         grant_seq.size() - g0, (grant_seq.size() > g0) ? grant_seq[g0] : -1);
    end
    pulse_rst();
    g0 = grant_seq.size();
    set_req(2, 1'b1, 1);
    for (int k = 0; k < 40 && grant_seq.size() == g0; k++) tick();
    client_req = '0;
    repeat (3) tick();
    n_checks++;
    if (grant_seq.size() == g0 || grant_seq[g0] != 2) begin
      n_fail++; $display("FAIL solo_c2: got %0d expected c2", (grant_seq.size() > g0) ? grant_seq[g0] : -1);
    end
    $display("post reset arbitration: done");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; force_rv = 1'b0; mem_ready = 1'b1;
    client_base_addr = '0; client_req = '0; client_we = '0; client_len = '0;
    for (int c = 0; c < N; c++) client_wdata[c*DW +: DW] = DW'(32'hC000 + c);
    test_reset();
    test_read_basic();
    test_rr_order();
    test_ready_toggle();
    test_wrap();
    test_edge_cases();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
